// File: rtl/vic_pkg.sv
// Shared defaults and FSM state type for the VICtor vector dispatch stage.
package vic_pkg;

  localparam int DEF_NUM_IRQ = 31;
  localparam int DEF_IDX_W   = 5;
  localparam int DEF_ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } vic_state_e;

endpackage

// File: rtl/vic_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index.
module vic_prio_enc #(
  parameter int NUM_IRQ = 31,
  parameter int IDX_W   = 5
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan downward so the lowest set bit is the last assignment.
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/vic_vector.sv
// Vector dispatch: strobe capture into a pending bitmap, priority pick,
// vector table lookup and the CPU request/ack/eoi handshake.
module vic_vector
  import vic_pkg::*;
#(
  parameter int NUM_IRQ = DEF_NUM_IRQ,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_irq_strobe,
  input  logic [IDX_W-1:0]   i_irq_addr,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [ADDR_W-1:0]  i_wr_data,
  input  logic               i_ack,
  input  logic               i_eoi,
  output logic               o_cpu_irq,
  output logic [ADDR_W-1:0]  o_vector,
  output logic [IDX_W-1:0]   o_irq_num,
  output logic               o_in_service,
  output logic [NUM_IRQ-1:0] o_pending,
  output logic               o_err
);

  localparam logic [IDX_W:0] NUM_LIM = (IDX_W + 1)'(NUM_IRQ);

  vic_state_e          state_q, state_d;
  logic                strobe_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic                err_q, err_d;
  logic                cpu_irq_q, cpu_irq_d;
  logic                in_svc_q, in_svc_d;
  logic [IDX_W-1:0]    num_q, num_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;
  logic [ADDR_W-1:0]   table_q [NUM_IRQ];

  logic                cap_rise;
  logic                cap_ok;
  logic                wr_ok;
  logic [IDX_W-1:0]    win_idx;
  logic                win_valid;

  assign cap_rise = i_irq_strobe & ~strobe_q;
  assign cap_ok   = {1'b0, i_irq_addr} < NUM_LIM;
  assign wr_ok    = {1'b0, i_wr_idx} < NUM_LIM;

  vic_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req   (pending_q),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = err_q;
    cpu_irq_d = cpu_irq_q;
    in_svc_d  = in_svc_q;
    num_d     = num_q;
    vec_d     = vec_q;

    case (state_q)
      IDLE: begin
        if (i_en && win_valid) begin
          num_d     = win_idx;
          vec_d     = table_q[win_idx];
          cpu_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (i_ack) begin
          pending_d[num_q] = 1'b0;
          cpu_irq_d        = 1'b0;
          in_svc_d         = 1'b1;
          state_d          = SERVICE;
        end else if (!i_en) begin
          cpu_irq_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SERVICE: begin
        if (i_eoi) begin
          in_svc_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture is applied after the ack clear so a same-cycle set wins.
    if (cap_rise) begin
      if (cap_ok) pending_d[i_irq_addr] = 1'b1;
      else        err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      strobe_q  <= 1'b0;
      pending_q <= '0;
      err_q     <= 1'b0;
      cpu_irq_q <= 1'b0;
      in_svc_q  <= 1'b0;
      num_q     <= '0;
      vec_q     <= '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) table_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= i_irq_strobe;
      pending_q <= pending_d;
      err_q     <= err_d;
      cpu_irq_q <= cpu_irq_d;
      in_svc_q  <= in_svc_d;
      num_q     <= num_d;
      vec_q     <= vec_d;
      if (i_wr_en && wr_ok) table_q[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_cpu_irq    = cpu_irq_q;
  assign o_vector     = vec_q;
  assign o_irq_num    = num_q;
  assign o_in_service = in_svc_q;
  assign o_pending    = pending_q;
  assign o_err        = err_q;

endmodule
